// File: rtl/fifo_pkg.sv
// Shared helpers and default sizes for both sides of the async FIFO.
// Gray/binary conversions work on a wide word; callers cast to their pointer width.
package fifo_pkg;
  localparam int P_SIZE_DEF = 4;
  localparam int D_SIZE_DEF = 8;
  localparam int PTR_MAX    = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
endpackage

// File: rtl/fifo_out_reg.sv
// First-word-fall-through output holding register of the FIFO read side.
// Load has priority over clear; otherwise the word is held.
module fifo_out_reg
  import fifo_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF
) (
  input  logic              w_clk,
  input  logic              w_rstn,
  input  logic              load,
  input  logic              clear,
  input  logic [D_SIZE-1:0] din,
  output logic [D_SIZE-1:0] dout,
  output logic              dout_valid
);

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= din;
      dout_valid <= 1'b1;
    end else if (clear) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd.sv
// Read side of an async FIFO: gray read pointer, memory addressing and FWFT output.
// Optional registered fill level when FIFO_RD_LEVEL_EN is defined.
module fifo_rd
  import fifo_pkg::*;
#(
  parameter int P_SIZE = P_SIZE_DEF,
  parameter int D_SIZE = D_SIZE_DEF
) (
  input  logic              w_clk,
  input  logic              w_rstn,
  input  logic [P_SIZE-1:0] sync_wr_ptr,
  input  logic [D_SIZE-1:0] mem_rdata,
  output logic [P_SIZE-2:0] r_addr,
  output logic [P_SIZE-1:0] r_ptr_gray,
  output logic [D_SIZE-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
`ifdef FIFO_RD_LEVEL_EN
  output logic [P_SIZE-1:0] level,
`endif
  output logic              empty
);

  logic [P_SIZE-1:0] rd_bin;
  logic [P_SIZE-1:0] rd_bin_nxt;
  logic              mem_empty;
  logic              load;
  logic              clear;

  // Compare in the gray domain so the synchronised pointer is used as-is.
  assign mem_empty  = (r_ptr_gray == sync_wr_ptr);
  assign load       = !mem_empty && (!dout_valid || dout_ready);
  assign clear      = dout_valid && dout_ready && mem_empty;
  assign rd_bin_nxt = rd_bin + {{(P_SIZE-1){1'b0}}, load};
  assign r_addr     = rd_bin[P_SIZE-2:0];
  assign empty      = !dout_valid;

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      rd_bin     <= '0;
      r_ptr_gray <= '0;
    end else begin
      rd_bin     <= rd_bin_nxt;
      r_ptr_gray <= P_SIZE'(bin2gray(PTR_MAX'(rd_bin_nxt)));
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  // Words held in memory plus the one parked in the output register.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      level <= '0;
    end else begin
      level <= P_SIZE'(gray2bin(PTR_MAX'(sync_wr_ptr))) - rd_bin
               + {{(P_SIZE-1){1'b0}}, dout_valid};
    end
  end
`endif

  fifo_out_reg #(
    .D_SIZE(D_SIZE)
  ) u_out_reg (
    .w_clk      (w_clk),
    .w_rstn     (w_rstn),
    .load       (load),
    .clear      (clear),
    .din        (mem_rdata),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

endmodule

// File: tb/tb_fifo_rd.sv
// Bench for fifo_rd: a modelled writer fills a small memory; a queue-based
// reference predicts the FWFT output stream, pointers and fill level.
module tb_fifo_rd;
  logic       w_clk = 1'b0;
  logic       w_rstn;
  logic [3:0] sync_wr_ptr;
  logic [7:0] mem_rdata;
  logic [2:0] r_addr;
  logic [3:0] r_ptr_gray;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [3:0] level;
`endif

  logic [7:0] tbmem [8];
  assign mem_rdata = tbmem[r_addr];

  fifo_rd #(.P_SIZE(4), .D_SIZE(8)) dut (
    .w_clk       (w_clk),
    .w_rstn      (w_rstn),
    .sync_wr_ptr (sync_wr_ptr),
    .mem_rdata   (mem_rdata),
    .r_addr      (r_addr),
    .r_ptr_gray  (r_ptr_gray),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
`ifdef FIFO_RD_LEVEL_EN
    .level       (level),
`endif
    .empty       (empty)
  );

  always #5 w_clk = ~w_clk;

  int         checks = 0;
  int         failures = 0;
  int         wr_cnt, m_rd, m_lvl;
  bit         m_vld;
  logic [7:0] m_data;
  logic [7:0] pending [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input logic [7:0] d);
    tbmem[wr_cnt % 8] = d;
    pending.push_back(d);
    wr_cnt++;
    sync_wr_ptr = to_gray(wr_cnt);
  endtask

  task automatic step(input bit rdy);
    dout_ready = rdy;
    m_lvl = pending.size() + int'(m_vld);
    if (pending.size() != 0 && (!m_vld || rdy)) begin
      m_data = pending.pop_front();
      m_vld  = 1'b1;
      m_rd++;
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    @(posedge w_clk);
    @(negedge w_clk);
    check("valid", 32'(dout_valid), 32'(m_vld));
    check("empty", 32'(empty), 32'(!m_vld));
    check("gray", 32'(r_ptr_gray), 32'(to_gray(m_rd)));
    check("addr", 32'(r_addr), 32'(m_rd % 8));
    if (m_vld) check("dout", 32'(dout), 32'(m_data));
`ifdef FIFO_RD_LEVEL_EN
    check("level", 32'(level), 32'(m_lvl % 16));
`endif
  endtask

  // Called at a falling edge; reset asserts mid low-phase and is checked before any edge.
  task automatic do_reset;
    #2;
    w_rstn      = 1'b0;
    sync_wr_ptr = 4'b0000;
    dout_ready  = 1'b0;
    #1;
    check("rst_gray", 32'(r_ptr_gray), 32'h0);
    check("rst_addr", 32'(r_addr), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
`ifdef FIFO_RD_LEVEL_EN
    check("rst_level", 32'(level), 32'h0);
`endif
    wr_cnt = 0;
    m_rd   = 0;
    m_vld  = 1'b0;
    m_lvl  = 0;
    pending.delete();
    @(negedge w_clk);
    w_rstn = 1'b1;
  endtask

  logic [3:0] gseq [8];

  initial begin
    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 8; i++) tbmem[i] = 8'h00;
    w_rstn      = 1'b0;
    sync_wr_ptr = 4'b0000;
    dout_ready  = 1'b0;
    @(negedge w_clk);

    // First word then hold with consumer stalled
    do_reset();
    push(8'hA5);
    step(1'b0);
    check("first_dout", 32'(dout), 32'hA5);
    check("first_gray", 32'(r_ptr_gray), 32'b0001);
    check("first_addr", 32'(r_addr), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b0);
    check("hold_dout", 32'(dout), 32'hA5);
    check("hold_valid", 32'(dout_valid), 32'h1);

    // Streaming eight words back to back
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    check("stream_sync", 32'(sync_wr_ptr), 32'b1100);
    for (int k = 0; k < 8; k++) begin
      step(1'b1);
      check("stream_gray", 32'(r_ptr_gray), 32'(gseq[k]));
      check("stream_dout", 32'(dout), 32'(8'h30 + k));
    end
    step(1'b1);
    check("stream_drop", 32'(dout_valid), 32'h0);

    // Pointer wrap from 15 to 0
    for (int i = 0; i < 7; i++) push(8'(8'h50 + i));
    for (int i = 0; i < 7; i++) step(1'b1);
    check("wrap_pre", 32'(r_ptr_gray), 32'b1000);
    push(8'hC3);
    check("wrap_sync", 32'(sync_wr_ptr), 32'b0000);
    step(1'b1);
    check("wrap_gray", 32'(r_ptr_gray), 32'b0000);
    check("wrap_addr", 32'(r_addr), 32'h0);
    check("wrap_dout", 32'(dout), 32'hC3);
    step(1'b1);
    check("wrap_empty", 32'(empty), 32'h1);

    // Reset while a word is held and three are pending
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
    step(1'b0);
    check("mid_valid", 32'(dout_valid), 32'h1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("post_rst_idle", 32'(dout_valid), 32'h0);
    end

`ifdef FIFO_RD_LEVEL_EN
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
    check("lvl_sync", 32'(sync_wr_ptr), 32'b0111);
    step(1'b0);
    check("lvl_level", 32'(level), 32'h5);
    check("lvl_valid", 32'(dout_valid), 32'h1);
    check("lvl_addr", 32'(r_addr), 32'h1);
`endif

    // Randomised traffic against the queue model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (pending.size() < 8 && $urandom_range(0, 2) != 0) push(8'($urandom));
      step($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
